// File: rtl/sampler_sequencer.sv
// Purpose : run controller for the dual-FIFO bus sampler. It arms a run by clearing the FIFOs and releasing masks, then drains rising/falling entries as ordered pairs to the host.
// Latency : all outputs registered; a pair costs 6 cycles from RUN when host_ready is held high (2 host words).
// Backpres: host_valid/host_data/host_tag hold while host_ready is low; no FIFO read is issued until the pending pair is fully accepted.
//
// Ports:
//   system_clock, reset_n      - clock and synchronous active-low reset
//   start, stop                - run control pulses (start honoured only when idle)
//   sample_limit, mask_cfg     - run parameters, latched at start ({cctl, s5, s4})
//   s4/s5/cctl_mask, clear     - sampler controls (mask=1 ignores that window)
//   posedge/negedge_read_enable- FIFO pops; data appears on sample_data one cycle later
//   posedge/negedge_empty/full - sampler FIFO flags
//   sample_data                - muxed FIFO output
//   host_data/tag/valid/ready  - host word stream; tag 0 = rising word, 1 = falling word
//   busy, overflow, pair_count - status
module sampler_sequencer #(
  parameter int CLEAR_CYCLES = 4,
  parameter int COUNT_WIDTH  = 24
) (
  input  logic                   system_clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] sample_limit,
  input  logic [2:0]             mask_cfg,
  output logic                   s4_mask,
  output logic                   s5_mask,
  output logic                   cctl_mask,
  output logic                   clear,
  output logic                   posedge_read_enable,
  output logic                   negedge_read_enable,
  input  logic                   posedge_empty,
  input  logic                   negedge_empty,
  input  logic                   posedge_full,
  input  logic                   negedge_full,
  input  logic [31:0]            sample_data,
  output logic [31:0]            host_data,
  output logic                   host_tag,
  output logic                   host_valid,
  input  logic                   host_ready,
  output logic                   busy,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] pair_count
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RD_P,
    S_CAP_P,
    S_CAP_N,
    S_SEND_P,
    S_SEND_N
  } state_t;

  // One word as presented on the host link.
  typedef struct packed {
    logic [31:0] dat;
    logic        tag;
  } host_word_t;

  // Control state
  state_t                 state_q,        state_d;
  logic [CLR_W-1:0]       clr_cnt_q,      clr_cnt_d;
  logic [2:0]             cfg_q,          cfg_d;
  logic [COUNT_WIDTH-1:0] limit_q,        limit_d;
  logic [31:0]            word_p_q,       word_p_d;
  logic [31:0]            word_n_q,       word_n_d;
  logic                   stop_pending_q, stop_pending_d;

  // Registered outputs
  logic [2:0]             masks_q,        masks_d;      // {cctl, s5, s4}
  logic                   clear_q,        clear_d;
  logic                   pre_q,          pre_d;
  logic                   nre_q,          nre_d;
  host_word_t             host_q,         host_d;
  logic                   host_valid_q,   host_valid_d;
  logic                   busy_q,         busy_d;
  logic                   overflow_q,     overflow_d;
  logic [COUNT_WIDTH-1:0] pair_count_q,   pair_count_d;

  logic [COUNT_WIDTH-1:0] pair_count_inc;
  logic                   in_run_phase;
  logic                   running_next;

  assign pair_count_inc = pair_count_q + COUNT_WIDTH'(1);
  assign in_run_phase   = (state_q != S_IDLE) && (state_q != S_CLEAR);

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    cfg_d          = cfg_q;
    limit_d        = limit_q;
    word_p_d       = word_p_q;
    word_n_d       = word_n_q;
    stop_pending_d = stop_pending_q;
    overflow_d     = overflow_q;
    pair_count_d   = pair_count_q;

    unique case (state_q)
      S_IDLE: begin
        // stop is ignored here, so start wins when both arrive together.
        if (start) begin
          state_d      = S_CLEAR;
          cfg_d        = mask_cfg;
          limit_d      = sample_limit;
          pair_count_d = '0;
          overflow_d   = 1'b0;
          clr_cnt_d    = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      S_RUN: begin
        // A single non-empty FIFO is a normal transient: wait for its partner.
        if (stop || stop_pending_q) begin
          state_d = S_IDLE;
        end else if (!posedge_empty && !negedge_empty) begin
          state_d = S_RD_P;
        end
      end
      S_RD_P: begin
        state_d = S_CAP_P;
      end
      S_CAP_P: begin
        // Rising entry lands one cycle after its read enable.
        word_p_d = sample_data;
        state_d  = S_CAP_N;
      end
      S_CAP_N: begin
        word_n_d = sample_data;
        state_d  = S_SEND_P;
      end
      S_SEND_P: begin
        if (host_ready) begin
          state_d = S_SEND_N;
        end
      end
      S_SEND_N: begin
        if (host_ready) begin
          pair_count_d = pair_count_inc;
          if ((limit_q != '0) && (pair_count_inc == limit_q)) begin
            state_d = S_IDLE;
          end else if (stop_pending_q || stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stop mid-pair is deferred so the pair is never split.
    if (stop && (state_q != S_IDLE) && (state_q != S_RUN)) begin
      stop_pending_d = 1'b1;
    end
    if (state_d == S_IDLE) begin
      stop_pending_d = 1'b0;
    end

    if (in_run_phase && (posedge_full || negedge_full)) begin
      overflow_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  assign running_next = (state_d != S_IDLE) && (state_d != S_CLEAR);

  always_comb begin
    masks_d      = running_next ? cfg_d : 3'b111;
    clear_d      = (state_d == S_CLEAR);
    pre_d        = (state_d == S_RD_P);
    nre_d        = (state_d == S_CAP_P);
    host_valid_d = (state_d == S_SEND_P) || (state_d == S_SEND_N);
    busy_d       = (state_d != S_IDLE);
    host_d       = host_q;
    if (state_d == S_SEND_P) begin
      host_d = '{dat: word_p_q, tag: 1'b0};
    end else if (state_d == S_SEND_N) begin
      host_d = '{dat: word_n_q, tag: 1'b1};
    end
  end

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      clr_cnt_q      <= '0;
      cfg_q          <= 3'b111;
      limit_q        <= '0;
      word_p_q       <= '0;
      word_n_q       <= '0;
      stop_pending_q <= 1'b0;
      masks_q        <= 3'b111;
      clear_q        <= 1'b0;
      pre_q          <= 1'b0;
      nre_q          <= 1'b0;
      host_q         <= '0;
      host_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      pair_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      cfg_q          <= cfg_d;
      limit_q        <= limit_d;
      word_p_q       <= word_p_d;
      word_n_q       <= word_n_d;
      stop_pending_q <= stop_pending_d;
      masks_q        <= masks_d;
      clear_q        <= clear_d;
      pre_q          <= pre_d;
      nre_q          <= nre_d;
      host_q         <= host_d;
      host_valid_q   <= host_valid_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
      pair_count_q   <= pair_count_d;
    end
  end

  assign s4_mask             = masks_q[0];
  assign s5_mask             = masks_q[1];
  assign cctl_mask           = masks_q[2];
  assign clear               = clear_q;
  assign posedge_read_enable = pre_q;
  assign negedge_read_enable = nre_q;
  assign host_data           = host_q.dat;
  assign host_tag            = host_q.tag;
  assign host_valid          = host_valid_q;
  assign busy                = busy_q;
  assign overflow            = overflow_q;
  assign pair_count          = pair_count_q;

endmodule
